// File: rtl/boundary_pkg.sv
// Shared types and constants for the macroblock boundary-context fetch block.
// Optional top-right fetch is enabled with the BOUNDARY_FETCH_TOPRIGHT_EN macro.
package boundary_pkg;

  // Default macroblock column index / RAM address width
  localparam int unsigned ADDR_W_DEFAULT = 10;

  // Frame-edge fill samples: above the picture and left of the picture
  localparam logic [7:0] FILL_TOP  = 8'd127;
  localparam logic [7:0] FILL_LEFT = 8'd129;

  // Byte-lane counts
  localparam int unsigned Y_LANES  = 16;  // luma row
  localparam int unsigned C_LANES  = 8;   // one chroma component row
  localparam int unsigned TR_LANES = 4;   // luma top-right extension

  typedef enum logic [2:0] {
    StIdle,
    StRdCur,
    StRdNxt,
    StCapt,
    StValid
  } state_e;

  // Byte 15 of a luma row, replicated across the top-right lanes
  function automatic logic [8*TR_LANES-1:0] replicate_last(input logic [8*Y_LANES-1:0] row);
    return {TR_LANES{row[8*Y_LANES-1 -: 8]}};
  endfunction

endpackage

// File: rtl/boundary_fill_mux.sv
// Combinational edge fill / selection of the prediction context: top row,
// top-right, left column and top-left corner, from captured RAM data and shadows.
module boundary_fill_mux
  import boundary_pkg::*;
(
  input  logic                     top_edge_i,   // macroblock row 0
  input  logic                     left_edge_i,  // macroblock column 0
  input  logic                     has_tr_i,     // next-entry top-right is available
  input  logic [8*Y_LANES-1:0]     cur_y_i,
  input  logic [16*C_LANES-1:0]    cur_uv_i,     // [63:0] U, [127:64] V
  input  logic [8*TR_LANES-1:0]    nxt_tr_i,     // bytes 0-3 of entry x+1
  input  logic [8*Y_LANES-1:0]     left_y_i,
  input  logic [8*C_LANES-1:0]     left_u_i,
  input  logic [8*C_LANES-1:0]     left_v_i,
  input  logic [7:0]               tl_y_i,
  input  logic [7:0]               tl_u_i,
  input  logic [7:0]               tl_v_i,
  output logic [8*(Y_LANES+TR_LANES)-1:0] top_y_o,
  output logic [8*C_LANES-1:0]     top_u_o,
  output logic [8*C_LANES-1:0]     top_v_o,
  output logic [8*Y_LANES-1:0]     left_y_o,
  output logic [8*C_LANES-1:0]     left_u_o,
  output logic [8*C_LANES-1:0]     left_v_o,
  output logic [7:0]               top_left_y_o,
  output logic [7:0]               top_left_u_o,
  output logic [7:0]               top_left_v_o
);

  logic [8*TR_LANES-1:0] top_right;

  // Top row and top-right: row 0 sees the above-picture fill
  always_comb begin
    top_right = has_tr_i ? nxt_tr_i : replicate_last(cur_y_i);
    if (top_edge_i) begin
      top_y_o = {(Y_LANES + TR_LANES){FILL_TOP}};
      top_u_o = {C_LANES{FILL_TOP}};
      top_v_o = {C_LANES{FILL_TOP}};
    end else begin
      top_y_o = {top_right, cur_y_i};
      top_u_o = cur_uv_i[8*C_LANES-1:0];
      top_v_o = cur_uv_i[16*C_LANES-1:8*C_LANES];
    end
  end

  // Left column: column 0 sees the left-of-picture fill
  always_comb begin
    if (left_edge_i) begin
      left_y_o = {Y_LANES{FILL_LEFT}};
      left_u_o = {C_LANES{FILL_LEFT}};
      left_v_o = {C_LANES{FILL_LEFT}};
    end else begin
      left_y_o = left_y_i;
      left_u_o = left_u_i;
      left_v_o = left_v_i;
    end
  end

  // Top-left corner: the above fill wins over the left fill at (0, 0)
  always_comb begin
    if (top_edge_i) begin
      top_left_y_o = FILL_TOP;
      top_left_u_o = FILL_TOP;
      top_left_v_o = FILL_TOP;
    end else if (left_edge_i) begin
      top_left_y_o = FILL_LEFT;
      top_left_u_o = FILL_LEFT;
      top_left_v_o = FILL_LEFT;
    end else begin
      top_left_y_o = tl_y_i;
      top_left_u_o = tl_u_i;
      top_left_v_o = tl_v_i;
    end
  end

endmodule

// File: rtl/boundary_fetch.sv
// Reader side of the macroblock top-row context store. Reads the Y/UV top-row
// RAMs for (x, y), merges left and top-left shadows, applies frame-edge fills
// and presents one registered context over valid/ready.
// Define BOUNDARY_FETCH_TOPRIGHT_EN to fetch the top-right from entry x+1.
module boundary_fetch
  import boundary_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] x_i,
  input  logic [ADDR_W-1:0] y_i,
  input  logic [ADDR_W-1:0] last_x_i,
  input  logic              left_load_i,
  input  logic [127:0]      left_y_i,
  input  logic [63:0]       left_u_i,
  input  logic [63:0]       left_v_i,
  output logic              y_rd_en_o,
  output logic              uv_rd_en_o,
  output logic [ADDR_W-1:0] y_rd_addr_o,
  output logic [ADDR_W-1:0] uv_rd_addr_o,
  input  logic [127:0]      y_rd_data_i,
  input  logic [127:0]      uv_rd_data_i,
  output logic              ctx_valid_o,
  input  logic              ctx_ready_i,
  output logic              busy_o,
  output logic [159:0]      top_y_o,
  output logic [63:0]       top_u_o,
  output logic [63:0]       top_v_o,
  output logic [127:0]      left_y_o,
  output logic [63:0]       left_u_o,
  output logic [63:0]       left_v_o,
  output logic [7:0]        top_left_y_o,
  output logic [7:0]        top_left_u_o,
  output logic [7:0]        top_left_v_o
);

  state_e state_q;

  logic [ADDR_W-1:0] x_q, y_q;
  logic              y_rd_en_q, uv_rd_en_q;
  logic [ADDR_W-1:0] y_rd_addr_q, uv_rd_addr_q;
  logic              ctx_valid_q;

  // Left-column shadow (follows left_load) and its snapshot taken at acceptance
  logic [127:0] lsh_y_q, snap_left_y_q;
  logic [63:0]  lsh_u_q, lsh_v_q, snap_left_u_q, snap_left_v_q;
  // Top-left shadow (updated per completed transfer) and its snapshot
  logic [7:0]   tsh_y_q, tsh_u_q, tsh_v_q;
  logic [7:0]   snap_tl_y_q, snap_tl_u_q, snap_tl_v_q;

  // Registered context outputs
  logic [159:0] top_y_q;
  logic [63:0]  top_u_q, top_v_q;
  logic [127:0] left_y_q;
  logic [63:0]  left_u_q, left_v_q;
  logic [7:0]   top_left_y_q, top_left_u_q, top_left_v_q;

  // Mux inputs and outputs
  logic [ADDR_W-1:0] sel_x, sel_y;
  logic [127:0]      sel_left_y;
  logic [63:0]       sel_left_u, sel_left_v;
  logic [7:0]        sel_tl_y, sel_tl_u, sel_tl_v;
  logic [127:0]      mux_cur_y, mux_cur_uv;
  logic [31:0]       mux_nxt_tr;
  logic              mux_has_tr;

  logic [159:0] mx_top_y;
  logic [63:0]  mx_top_u, mx_top_v;
  logic [127:0] mx_left_y;
  logic [63:0]  mx_left_u, mx_left_v;
  logic [7:0]   mx_tl_y, mx_tl_u, mx_tl_v;

`ifdef BOUNDARY_FETCH_TOPRIGHT_EN
  logic [ADDR_W-1:0] last_x_q;
  logic [127:0]      cur_y_q, cur_uv_q;

  // Current entry is held from RD_NXT; next entry arrives straight from RAM in CAPT
  assign mux_cur_y  = cur_y_q;
  assign mux_cur_uv = cur_uv_q;
  assign mux_nxt_tr = y_rd_data_i[31:0];
  assign mux_has_tr = (x_q < last_x_q);
`else
  logic unused_last_x;
  assign unused_last_x = ^last_x_i;

  // Current entry arrives straight from RAM in CAPT; top-right is always replicated
  assign mux_cur_y  = y_rd_data_i;
  assign mux_cur_uv = uv_rd_data_i;
  assign mux_nxt_tr = '0;
  assign mux_has_tr = 1'b0;
`endif

  // In IDLE the mux sees the live request (y == 0 completes at acceptance);
  // otherwise it sees the values snapshotted when the request was accepted.
  always_comb begin
    sel_x      = x_q;
    sel_y      = y_q;
    sel_left_y = snap_left_y_q;
    sel_left_u = snap_left_u_q;
    sel_left_v = snap_left_v_q;
    sel_tl_y   = snap_tl_y_q;
    sel_tl_u   = snap_tl_u_q;
    sel_tl_v   = snap_tl_v_q;
    if (state_q == StIdle) begin
      sel_x    = x_i;
      sel_y    = y_i;
      sel_tl_y = tsh_y_q;
      sel_tl_u = tsh_u_q;
      sel_tl_v = tsh_v_q;
      // A coincident left_load wins over the stored shadow
      if (left_load_i) begin
        sel_left_y = left_y_i;
        sel_left_u = left_u_i;
        sel_left_v = left_v_i;
      end else begin
        sel_left_y = lsh_y_q;
        sel_left_u = lsh_u_q;
        sel_left_v = lsh_v_q;
      end
    end
  end

  boundary_fill_mux u_fill_mux (
    .top_edge_i   (sel_y == '0),
    .left_edge_i  (sel_x == '0),
    .has_tr_i     (mux_has_tr),
    .cur_y_i      (mux_cur_y),
    .cur_uv_i     (mux_cur_uv),
    .nxt_tr_i     (mux_nxt_tr),
    .left_y_i     (sel_left_y),
    .left_u_i     (sel_left_u),
    .left_v_i     (sel_left_v),
    .tl_y_i       (sel_tl_y),
    .tl_u_i       (sel_tl_u),
    .tl_v_i       (sel_tl_v),
    .top_y_o      (mx_top_y),
    .top_u_o      (mx_top_u),
    .top_v_o      (mx_top_v),
    .left_y_o     (mx_left_y),
    .left_u_o     (mx_left_u),
    .left_v_o     (mx_left_v),
    .top_left_y_o (mx_tl_y),
    .top_left_u_o (mx_tl_u),
    .top_left_v_o (mx_tl_v)
  );

  // FSM, RAM read issue, data captures, shadows and registered context outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      y_rd_en_q     <= 1'b0;
      uv_rd_en_q    <= 1'b0;
      y_rd_addr_q   <= '0;
      uv_rd_addr_q  <= '0;
      ctx_valid_q   <= 1'b0;
      lsh_y_q       <= '0;
      lsh_u_q       <= '0;
      lsh_v_q       <= '0;
      snap_left_y_q <= '0;
      snap_left_u_q <= '0;
      snap_left_v_q <= '0;
      tsh_y_q       <= '0;
      tsh_u_q       <= '0;
      tsh_v_q       <= '0;
      snap_tl_y_q   <= '0;
      snap_tl_u_q   <= '0;
      snap_tl_v_q   <= '0;
      top_y_q       <= '0;
      top_u_q       <= '0;
      top_v_q       <= '0;
      left_y_q      <= '0;
      left_u_q      <= '0;
      left_v_q      <= '0;
      top_left_y_q  <= '0;
      top_left_u_q  <= '0;
      top_left_v_q  <= '0;
`ifdef BOUNDARY_FETCH_TOPRIGHT_EN
      last_x_q      <= '0;
      cur_y_q       <= '0;
      cur_uv_q      <= '0;
`endif
    end else begin
      if (left_load_i) begin
        lsh_y_q <= left_y_i;
        lsh_u_q <= left_u_i;
        lsh_v_q <= left_v_i;
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            x_q           <= x_i;
            y_q           <= y_i;
            snap_left_y_q <= sel_left_y;
            snap_left_u_q <= sel_left_u;
            snap_left_v_q <= sel_left_v;
            snap_tl_y_q   <= tsh_y_q;
            snap_tl_u_q   <= tsh_u_q;
            snap_tl_v_q   <= tsh_v_q;
`ifdef BOUNDARY_FETCH_TOPRIGHT_EN
            last_x_q      <= last_x_i;
`endif
            if (y_i != '0) begin
              state_q      <= StRdCur;
              y_rd_en_q    <= 1'b1;
              uv_rd_en_q   <= 1'b1;
              y_rd_addr_q  <= x_i;
              uv_rd_addr_q <= x_i;
            end else begin
              // Top row is all fill: no RAM access needed
              state_q      <= StValid;
              ctx_valid_q  <= 1'b1;
              top_y_q      <= mx_top_y;
              top_u_q      <= mx_top_u;
              top_v_q      <= mx_top_v;
              left_y_q     <= mx_left_y;
              left_u_q     <= mx_left_u;
              left_v_q     <= mx_left_v;
              top_left_y_q <= mx_tl_y;
              top_left_u_q <= mx_tl_u;
              top_left_v_q <= mx_tl_v;
            end
          end
        end

        StRdCur: begin
          uv_rd_en_q <= 1'b0;
`ifdef BOUNDARY_FETCH_TOPRIGHT_EN
          // Only read entry x+1 when it exists; cadence stays fixed either way
          state_q     <= StRdNxt;
          y_rd_en_q   <= (x_q < last_x_q);
          y_rd_addr_q <= x_q + ADDR_W'(1);
`else
          state_q     <= StCapt;
          y_rd_en_q   <= 1'b0;
`endif
        end

`ifdef BOUNDARY_FETCH_TOPRIGHT_EN
        StRdNxt: begin
          state_q   <= StCapt;
          y_rd_en_q <= 1'b0;
          cur_y_q   <= y_rd_data_i;
          cur_uv_q  <= uv_rd_data_i;
        end
`endif

        StCapt: begin
          state_q      <= StValid;
          ctx_valid_q  <= 1'b1;
          top_y_q      <= mx_top_y;
          top_u_q      <= mx_top_u;
          top_v_q      <= mx_top_v;
          left_y_q     <= mx_left_y;
          left_u_q     <= mx_left_u;
          left_v_q     <= mx_left_v;
          top_left_y_q <= mx_tl_y;
          top_left_u_q <= mx_tl_u;
          top_left_v_q <= mx_tl_v;
        end

        StValid: begin
          if (ctx_ready_i) begin
            state_q     <= StIdle;
            ctx_valid_q <= 1'b0;
            // Bottom-right samples of this top row become the next top-left
            if (y_q != '0) begin
              tsh_y_q <= top_y_q[127:120];
              tsh_u_q <= top_u_q[63:56];
              tsh_v_q <= top_v_q[63:56];
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign y_rd_en_o    = y_rd_en_q;
  assign uv_rd_en_o   = uv_rd_en_q;
  assign y_rd_addr_o  = y_rd_addr_q;
  assign uv_rd_addr_o = uv_rd_addr_q;
  assign ctx_valid_o  = ctx_valid_q;
  assign top_y_o      = top_y_q;
  assign top_u_o      = top_u_q;
  assign top_v_o      = top_v_q;
  assign left_y_o     = left_y_q;
  assign left_u_o     = left_u_q;
  assign left_v_o     = left_v_q;
  assign top_left_y_o = top_left_y_q;
  assign top_left_u_o = top_left_u_q;
  assign top_left_v_o = top_left_v_q;

endmodule

// File: tb/tb_boundary_fetch.sv
// Directed bench for boundary_fetch; expectations follow BOUNDARY_FETCH_TOPRIGHT_EN.
module tb_boundary_fetch;

`ifdef BOUNDARY_FETCH_TOPRIGHT_EN
  localparam int          LAT  = 4;
  localparam logic [31:0] TR3  = 32'h13121110;
  localparam int          NRD3 = 2;
`else
  localparam int          LAT  = 3;
  localparam logic [31:0] TR3  = 32'h0F0F0F0F;
  localparam int          NRD3 = 1;
`endif

  localparam logic [127:0] E3   = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] UV3  = 128'h4F4E4D4C4B4A49484746454443424140;
  localparam logic [127:0] E10  = 128'h5C0E0D0C0B0A09080706050403020100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, left_load, ctx_ready;
  logic [9:0]   x, y, last_x;
  logic [127:0] left_y_in;
  logic [63:0]  left_u_in, left_v_in;
  logic         y_rd_en, uv_rd_en, ctx_valid, busy;
  logic [9:0]   y_rd_addr, uv_rd_addr;
  logic [127:0] y_rd_data, uv_rd_data;
  logic [159:0] top_y;
  logic [63:0]  top_u, top_v, left_u, left_v;
  logic [127:0] left_y;
  logic [7:0]   tl_y, tl_u, tl_v;

  logic [127:0] yram  [0:1023];
  logic [127:0] uvram [0:1023];
  logic [9:0]   ylog[$];
  logic [9:0]   uvlog[$];

  int ncmp  = 0;
  int nfail = 0;
  int lat;

  boundary_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .x_i          (x),
    .y_i          (y),
    .last_x_i     (last_x),
    .left_load_i  (left_load),
    .left_y_i     (left_y_in),
    .left_u_i     (left_u_in),
    .left_v_i     (left_v_in),
    .y_rd_en_o    (y_rd_en),
    .uv_rd_en_o   (uv_rd_en),
    .y_rd_addr_o  (y_rd_addr),
    .uv_rd_addr_o (uv_rd_addr),
    .y_rd_data_i  (y_rd_data),
    .uv_rd_data_i (uv_rd_data),
    .ctx_valid_o  (ctx_valid),
    .ctx_ready_i  (ctx_ready),
    .busy_o       (busy),
    .top_y_o      (top_y),
    .top_u_o      (top_u),
    .top_v_o      (top_v),
    .left_y_o     (left_y),
    .left_u_o     (left_u),
    .left_v_o     (left_v),
    .top_left_y_o (tl_y),
    .top_left_u_o (tl_u),
    .top_left_v_o (tl_v)
  );

  // Synchronous-read RAMs: data valid the cycle after enable
  always @(posedge clk) begin
    if (y_rd_en) y_rd_data <= yram[y_rd_addr];
    if (uv_rd_en) uv_rd_data <= uvram[uv_rd_addr];
  end

  // Read log sampled mid-cycle
  always @(negedge clk) begin
    if (y_rd_en) ylog.push_back(y_rd_addr);
    if (uv_rd_en) uvlog.push_back(uv_rd_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [9:0] xx, input logic [9:0] yy, input logic [9:0] lx);
    x = xx; y = yy; last_x = lx; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles from acceptance edge to ctx_valid, bounded
  task automatic wait_valid(output int l);
    l = 1;
    while (!ctx_valid && l < 20) begin
      tick();
      l++;
    end
  endtask

  task automatic xfer();
    ctx_ready = 1'b1;
    tick();
    ctx_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      yram[i]  = '0;
      uvram[i] = '0;
    end
    yram[3]   = E3;
    yram[4]   = 128'h1F1E1D1C1B1A19181716151413121110;
    uvram[3]  = UV3;
    yram[10]  = E10;
    yram[11]  = {16{8'hEE}};
    yram[12]  = {8'h77, 120'h0};
    yram[13]  = {16{8'hEE}};
    rst = 1'b1; start = 1'b0; left_load = 1'b0; ctx_ready = 1'b0;
    x = '0; y = '0; last_x = 10'd10;
    left_y_in = '0; left_u_in = '0; left_v_in = '0;
    tick(); tick();

    // Reset state
    chk("rst_ctl", {ctx_valid, busy, y_rd_en, uv_rd_en}, 4'b0000);
    chk("rst_addr", {y_rd_addr, uv_rd_addr}, 20'h0);
    chk("rst_top_y", top_y, 160'h0);
    chk("rst_left", {left_y, left_u, left_v}, 256'h0);
    chk("rst_tl", {tl_y, tl_u, tl_v}, 24'h0);
    rst = 1'b0;
    tick();

    // (0,0): all fill, one-cycle latency, no RAM access
    ylog.delete(); uvlog.delete();
    launch(10'd0, 10'd0, 10'd10);
    wait_valid(lat);
    chk("y0_lat", lat, 1);
    chk("y0_top_y", top_y, {20{8'h7F}});
    chk("y0_top_uv", {top_u, top_v}, {16{8'h7F}});
    chk("y0_left", {left_y, left_u, left_v}, {32{8'h81}});
    chk("y0_tl", {tl_y, tl_u, tl_v}, {3{8'h7F}});
    xfer();
    chk("y0_no_rd", ylog.size() + uvlog.size(), 0);

    // Interior macroblock (3,2) with prior left load
    left_load = 1'b1;
    left_y_in = {16{8'hAA}}; left_u_in = {8{8'hBB}}; left_v_in = {8{8'hCC}};
    tick();
    left_load = 1'b0;
    ylog.delete(); uvlog.delete();
    launch(10'd3, 10'd2, 10'd10);
    wait_valid(lat);
    chk("mb3_lat", lat, LAT);
    chk("mb3_top_y", top_y, {TR3, E3});
    chk("mb3_top_u", top_u, UV3[63:0]);
    chk("mb3_top_v", top_v, UV3[127:64]);
    chk("mb3_left", {left_y, left_u, left_v}, {{16{8'hAA}}, {8{8'hBB}}, {8{8'hCC}}});
    chk("mb3_tl", {tl_y, tl_u, tl_v}, 24'h0);
    chk("mb3_nyrd", ylog.size(), NRD3);
    chk("mb3_yaddr0", ylog[0], 10'd3);
`ifdef BOUNDARY_FETCH_TOPRIGHT_EN
    chk("mb3_yaddr1", ylog[1], 10'd4);
`endif
    chk("mb3_uvrd", {uvlog.size(), 10'(uvlog[0])}, {32'd1, 10'd3});
    xfer();
    chk("mb3_done", {ctx_valid, busy}, 2'b00);

    // Rightmost column: replicated top-right, constant latency
    ylog.delete();
    launch(10'd10, 10'd1, 10'd10);
    wait_valid(lat);
    chk("mb10_lat", lat, LAT);
    chk("mb10_top_y", top_y, {32'h5C5C5C5C, E10});
    chk("mb10_one_rd", {ylog.size(), 10'(ylog[0])}, {32'd1, 10'd10});
    chk("mb10_tl", {tl_y, tl_u, tl_v}, {8'h0F, 8'h47, 8'h4F});

    // Back-pressure: outputs held, starts ignored, left_load does not disturb
    for (int k = 0; k < 5; k++) begin
      left_load = 1'b1;
      left_y_in = {16{8'h11}}; left_u_in = {8{8'h12}}; left_v_in = {8{8'h13}};
      x = '0; y = '0; start = 1'b1;
      tick();
      chk("hold_vb", {ctx_valid, busy}, 2'b11);
      chk("hold_top_y", top_y, {32'h5C5C5C5C, E10});
      chk("hold_left_tl", {left_y, tl_y}, {{16{8'hAA}}, 8'h0F});
    end
    start = 1'b0; left_load = 1'b0;
    xfer();
    chk("hold_done", {ctx_valid, busy}, 2'b00);
    tick(); tick();
    chk("no_queue", {ctx_valid, busy}, 2'b00);

    // Top-left propagation between consecutive macroblocks
    yram[4][127:120] = 8'h33;
    launch(10'd4, 10'd1, 10'd10);
    wait_valid(lat);
    chk("mb4_tl_y", tl_y, 8'h5C);
    chk("mb4_left", {left_y, left_u, left_v}, {{16{8'h11}}, {8{8'h12}}, {8{8'h13}}});
    xfer();
    // left_load coincident with start: new data used
    left_load = 1'b1;
    left_y_in = {16{8'h22}}; left_u_in = {8{8'h23}}; left_v_in = {8{8'h24}};
    x = 10'd5; y = 10'd1; last_x = 10'd10; start = 1'b1;
    tick();
    start = 1'b0; left_load = 1'b0;
    left_y_in = {16{8'h99}};
    wait_valid(lat);
    chk("mb5_lat", lat, LAT);
    chk("mb5_tl_y", tl_y, 8'h33);
    chk("mb5_left_y", left_y, {16{8'h22}});
    xfer();
    launch(10'd0, 10'd1, 10'd10);
    wait_valid(lat);
    chk("mb0_tl", {tl_y, tl_u, tl_v}, {3{8'h81}});
    chk("mb0_left_y", left_y, {16{8'h81}});
    chk("mb0_top_y", top_y, 160'h0);
    xfer();

    // x beyond last_x: read address stays x, top-right replicated
    ylog.delete();
    launch(10'd12, 10'd1, 10'd10);
    wait_valid(lat);
    chk("mb12_top_y", top_y, {32'h77777777, 8'h77, 120'h0});
    chk("mb12_rd", {ylog.size(), 10'(ylog[0])}, {32'd1, 10'd12});
    xfer();

    // Reset in the middle of a fetch
    launch(10'd3, 10'd2, 10'd10);
    tick();
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_ctl", {ctx_valid, busy, y_rd_en, uv_rd_en}, 4'b0000);
    chk("mid_rst_data", {top_y, left_y, tl_y}, 296'h0);
    rst = 1'b0;
    tick();
    ylog.delete();
    launch(10'd3, 10'd2, 10'd10);
    wait_valid(lat);
    chk("post_lat", lat, LAT);
    chk("post_top_y", top_y, {TR3, E3});
    chk("post_left_tl", {left_y, tl_y}, 136'h0);
    xfer();
    chk("post_done", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/boundary_fetch.md
# boundary_fetch

Reader side of the macroblock top-row context store. On request for macroblock (x, y) it reads the Y and UV top-row RAMs, captures the current and top-right entries, merges in the latched left column and top-left samples, and applies the frame-edge fill values (127 above, 129 left). It then presents one complete prediction context to the intra-prediction stage over a valid/ready handshake. It sits between the two top-row RAMs and the predictor.

## Interface
- ADDR_W, 10, macroblock column index / RAM address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a context for (x, y); accepted only in IDLE
- x, y  in  ADDR_W  macroblock column / row, sampled on acceptance
- last_x  in  ADDR_W  index of the rightmost macroblock column
- left_load  in  1  latch left-column samples of the just-reconstructed macroblock
- left_y_i  in  128  byte i = row i of the rightmost luma column
- left_u_i, left_v_i  in  64 each  byte i = row i of the rightmost chroma column
- y_rd_en, uv_rd_en  out  1  RAM read enables (registered)
- y_rd_addr, uv_rd_addr  out  ADDR_W  RAM read addresses (registered)
- y_rd_data  in  128  luma top row; byte i = pixel i; valid the cycle after enable
- uv_rd_data  in  128  [63:0] = U, [127:64] = V; same latency
- ctx_valid  out  1  context outputs valid
- ctx_ready  in  1  consumer accepts
- busy  out  1  state != IDLE
- top_y  out  160  bytes 0–15 top row, bytes 16–19 top-right
- top_u, top_v  out  64 each
- left_y  out  128; left_u, left_v  out  64 each
- top_left_y, top_left_u, top_left_v  out  8 each

## Operation
- FSM states: IDLE, RD_CUR, RD_NXT, CAPT, VALID.
- IDLE with start and y != 0 → RD_CUR. IDLE with start and y == 0 → VALID directly.
- RD_CUR: y_rd_en = uv_rd_en = 1, both addresses = x.
- RD_NXT: capture the current Y and UV data. If x < last_x: y_rd_en = 1, y_rd_addr = x+1. Otherwise no read is issued. uv_rd_en = 0.
- CAPT: capture the next-entry Y data. Then → VALID.
- VALID: hold all outputs. ctx_valid && ctx_ready → IDLE.
- Top fill:
  - y == 0: top_y, top_u, top_v are all 127; top_left_y/u/v = 127.
  - Otherwise top comes from the captured data.
- Top-right (top_y[159:128]):
  - x < last_x: bytes 0–3 of entry x+1.
  - x == last_x: byte 15 of the current entry replicated 4×.
  - y == 0: 127.
- Left selection:
  - x == 0: left_y/u/v are all 129; top_left = 129 when y > 0.
  - Otherwise left comes from the left shadow registers.
- Left shadow: every left_load cycle overwrites it. If left_load and start coincide, the new data is used.
- Top-left shadow: on each completed transfer with y > 0, store top_y byte 15, top_u byte 7 and top_v byte 7. These become top_left for the next macroblock when x > 0.
- Left and top-left snapshots are taken at start acceptance. A later left_load does not disturb a context in flight.
- start while busy is ignored, with no queueing.
- x > last_x is treated as x == last_x for top-right; the read address is still x.

## Timing
- Reset values:
  - FSM = IDLE.
  - ctx_valid, busy, y_rd_en, uv_rd_en = 0; addresses = 0.
  - All context outputs and all shadow registers = 0.
- Reset mid-operation aborts immediately. No read enable is asserted after reset.
- With y != 0, start is accepted at edge n:
  - cycle n+1: RD_CUR
  - cycle n+2: RD_NXT
  - cycle n+3: CAPT
  - ctx_valid rises in cycle n+4
- This latency of 4 is constant, including when x == last_x.
- With y == 0: ctx_valid rises in cycle n+1, with no RAM access.
- The transfer completes on the edge where ctx_valid && ctx_ready. busy falls the next cycle, and the next start is accepted no earlier than that.
- Outputs are stable while ctx_valid && !ctx_ready.

## Configuration
- BOUNDARY_FETCH_TOPRIGHT_EN defined: behaviour as above.
- BOUNDARY_FETCH_TOPRIGHT_EN undefined:
  - RD_NXT is removed; the current data is captured in CAPT.
  - top_y[159:128] is always byte 15 replicated, or 127 when y == 0.
  - Latency for y != 0 is 3 cycles.

## Structure
- Package boundary_pkg:
  - FILL_TOP = 8'd127, FILL_LEFT = 8'd129
  - state enum
  - ADDR_W default
  - byte-lane helper constants (Y 16 lanes, chroma 8 lanes)
- One natural sub-module, boundary_fill_mux: combinational fill/select of top, top-right, left and top-left from the captured data, edge flags and shadows. The FSM, captures and shadows stay in boundary_fetch.

## Test plan
- Reset, then x=0, y=0, start → ctx_valid at n+1; top_y all 0x7F, left_y all 0x81, top_left_y 0x7F; no rd_en ever asserted.
- RAM entry 3 = 0x00..0x0F, entry 4 = 0x10..0x1F, x=3, y=2, last_x=10, prior left_load 0xAA → rd addresses 3 then 4; ctx_valid at n+4; top_y[159:128] = 0x13121110; left_y all 0xAA.
- x=last_x=10, y=1, entry 10 byte 15 = 0x5C → only one Y read; top_y[159:128] = 0x5C5C5C5C; ctx_valid still at n+4.
- ctx_ready held low 5 cycles in VALID, with left_load of new data and start pulses during that time → outputs unchanged, starts ignored, busy held; transfer on ready.
- Consecutive macroblocks x=4 then x=5, y=1, first top_y byte 15 = 0x33 → second context top_left_y = 0x33; x=0 → top_left_y = 0x81.
- rst pulsed during RD_NXT → all outputs 0 next cycle; a fresh start completes normally. Rerun the regression with the macro undefined: latency 3, top-right replicated.
